alu_issue: RTL and testbench

Decode-and-issue stage feeding the integer ALU. Accepts one RV32I instruction per cycle with its PC and register-file read data, and produces registered ALU operands (`ra`, `rb`), unit selects, `op`, and writeback control. Sits between fetch/regfile read and the ALU. A two-entry skid buffer gives full throughput with a registered `in_ready`.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_decode.sv | 97 +++++++++
 rtl/alu_issue.sv | 129 ++++++++++++
 tb/tb_alu_issue.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings and the decoded-payload type for the ALU decode/issue stage.
// Opcode, unit-op and funct7 constants, plus the skid-buffer state type.
package alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] AU_ADD  = 2'b00;
    localparam logic [1:0] AU_SUB  = 2'b01;
    localparam logic [1:0] AU_SLT  = 2'b10;
    localparam logic [1:0] AU_SLTU = 2'b11;

    localparam logic [1:0] LU_AND   = 2'b00;
    localparam logic [1:0] LU_OR    = 2'b01;
    localparam logic [1:0] LU_XOR   = 2'b10;
    localparam logic [1:0] LU_PASSB = 2'b11;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;

    typedef struct packed {
        logic [31:0] ra;
        logic [31:0] rb;
        logic        sel_logic;
        logic        sel_shift;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
    } issue_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode for the integer ALU: instruction plus operands in,
// fully resolved issue payload out. Illegal encodings produce a zeroed payload.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] insn,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output issue_t      dec
);

    logic [6:0]         opc;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [4:0]         rd;
    logic signed [31:0] imm_i;
    logic [31:0]        imm_u;
    logic [31:0]        shamt;
    logic               legal;

    assign opc   = insn[6:0];
    assign rd    = insn[11:7];
    assign f3    = insn[14:12];
    assign f7    = insn[31:25];
    assign imm_i = $signed({{20{insn[31]}}, insn[31:20]});
    assign imm_u = {insn[31:12], 12'h000};
    assign shamt = {27'b0, insn[24:20]};

    always_comb begin
        legal = 1'b0;
        dec   = '0;
        dec.rd = rd;
        unique case (opc)
            OPC_OP: begin
                dec.ra = rs1_data;
                dec.rb = rs2_data;
                unique case (f3)
                    3'b000: begin
                        legal  = (f7 == F7_BASE) || (f7 == F7_ALT);
                        dec.op = (f7 == F7_ALT) ? AU_SUB : AU_ADD;
                    end
                    3'b001: begin legal = (f7 == F7_BASE); dec.sel_shift = 1'b1; dec.op = SH_SLL; end
                    3'b010: begin legal = (f7 == F7_BASE); dec.op = AU_SLT; end
                    3'b011: begin legal = (f7 == F7_BASE); dec.op = AU_SLTU; end
                    3'b100: begin legal = (f7 == F7_BASE); dec.sel_logic = 1'b1; dec.op = LU_XOR; end
                    3'b101: begin
                        legal         = (f7 == F7_BASE) || (f7 == F7_ALT);
                        dec.sel_shift = 1'b1;
                        dec.op        = (f7 == F7_ALT) ? SH_SRA : SH_SRL;
                    end
                    3'b110: begin legal = (f7 == F7_BASE); dec.sel_logic = 1'b1; dec.op = LU_OR; end
                    default: begin legal = (f7 == F7_BASE); dec.sel_logic = 1'b1; dec.op = LU_AND; end
                endcase
            end
            OPC_OP_IMM: begin
                dec.ra = rs1_data;
                dec.rb = imm_i;
                unique case (f3)
                    3'b000: begin legal = 1'b1; dec.op = AU_ADD; end
                    3'b001: begin
                        legal = (f7 == F7_BASE); dec.sel_shift = 1'b1; dec.op = SH_SLL; dec.rb = shamt;
                    end
                    3'b010: begin legal = 1'b1; dec.op = AU_SLT; end
                    3'b011: begin legal = 1'b1; dec.op = AU_SLTU; end
                    3'b100: begin legal = 1'b1; dec.sel_logic = 1'b1; dec.op = LU_XOR; end
                    3'b101: begin
                        legal         = (f7 == F7_BASE) || (f7 == F7_ALT);
                        dec.sel_shift = 1'b1;
                        dec.op        = (f7 == F7_ALT) ? SH_SRA : SH_SRL;
                        dec.rb        = shamt;
                    end
                    3'b110: begin legal = 1'b1; dec.sel_logic = 1'b1; dec.op = LU_OR; end
                    default: begin legal = 1'b1; dec.sel_logic = 1'b1; dec.op = LU_AND; end
                endcase
            end
            OPC_LUI: begin
                legal = 1'b1; dec.sel_logic = 1'b1; dec.op = LU_PASSB; dec.ra = '0; dec.rb = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1; dec.op = AU_ADD; dec.ra = pc; dec.rb = imm_u;
            end
            default: legal = 1'b0;
        endcase
        // Illegal entries still flow in order but must not steer any unit.
        if (!legal) begin
            dec.ra        = '0;
            dec.rb        = '0;
            dec.sel_logic = 1'b0;
            dec.sel_shift = 1'b0;
            dec.op        = '0;
        end
        dec.illegal = !legal;
        dec.we      = legal && (rd != 5'd0);
    end

endmodule

// File: rtl/alu_issue.sv
// Decode-and-issue stage: decodes on the input side and holds up to two decoded
// entries (main + skid) so in_ready can be a register without losing throughput.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_insn,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_ra,
    output logic [XLEN-1:0] out_rb,
    output logic            out_sel_logic,
    output logic            out_sel_shift,
    output logic [1:0]      out_op,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_illegal
);

    issue_t      dec_p0;
    issue_t      main_p1;
    issue_t      skid_p1;
    skid_state_e state_q;
    skid_state_e state_d;
    logic        in_ready_q;
    logic        accept;
    logic        issue;
    logic        load_main;
    logic        load_skid;
    logic        skid_to_main;

    assign rs1_addr = in_insn[19:15];
    assign rs2_addr = in_insn[24:20];

    alu_decode u_decode (
        .insn     (in_insn),
        .pc       (in_pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .dec      (dec_p0)
    );

    assign accept = in_valid && in_ready_q;
    assign issue  = (state_q != ST_EMPTY) && out_ready;

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && issue) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (issue) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (issue) begin
                    state_d      = ST_ONE;
                    skid_to_main = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over any handshake in the same cycle, including the accept.
        if (flush) begin
            state_d      = ST_EMPTY;
            load_main    = 1'b0;
            load_skid    = 1'b0;
            skid_to_main = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // p0 -> p1: decoded payload captured into main or skid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_p1 <= '0;
            skid_p1 <= '0;
        end else begin
            if (load_main)         main_p1 <= dec_p0;
            else if (skid_to_main) main_p1 <= skid_p1;
            if (load_skid)         skid_p1 <= dec_p0;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = (state_q != ST_EMPTY);
    assign out_ra        = main_p1.ra;
    assign out_rb        = main_p1.rb;
    assign out_sel_logic = main_p1.sel_logic;
    assign out_sel_shift = main_p1.sel_shift;
    assign out_op        = main_p1.op;
    assign out_rd        = main_p1.rd;
    assign out_we        = main_p1.we;
    assign out_illegal   = main_p1.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed test-plan sequences plus randomized traffic,
// checked against an instruction-level decode model and an in-order queue.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_insn;
    logic [31:0] in_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ra;
    logic [31:0] out_rb;
    logic        out_sel_logic;
    logic        out_sel_shift;
    logic [1:0]  out_op;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    always #5 clk = ~clk;

    alu_issue #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_insn       (in_insn),
        .in_pc         (in_pc),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ra        (out_ra),
        .out_rb        (out_rb),
        .out_sel_logic (out_sel_logic),
        .out_sel_shift (out_sel_shift),
        .out_op        (out_op),
        .out_rd        (out_rd),
        .out_we        (out_we),
        .out_illegal   (out_illegal)
    );

    typedef struct {
        logic [31:0] ra;
        logic [31:0] rb;
        logic        sl;
        logic        ss;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];
    logic m_ready;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    // Instruction-level meaning of each RV32I ALU instruction.
    function automatic exp_t ref_decode(input logic [31:0] insn, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic        ok;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] immi;
        logic [31:0] immu;
        f7   = insn[31:25];
        f3   = insn[14:12];
        immi = {{20{insn[31]}}, insn[31:20]};
        immu = {insn[31:12], 12'h000};
        e    = '{default: '0};
        e.rd = insn[11:7];
        ok   = 1'b0;
        if (insn[6:0] == 7'h33) begin
            e.ra = r1;
            e.rb = r2;
            case (f3)
                3'd0: begin ok = (f7 == 7'h00) || (f7 == 7'h20); e.op = (f7 == 7'h20) ? 2'd1 : 2'd0; end
                3'd1: begin ok = (f7 == 7'h00); e.ss = 1'b1; e.op = 2'd0; end
                3'd2: begin ok = (f7 == 7'h00); e.op = 2'd2; end
                3'd3: begin ok = (f7 == 7'h00); e.op = 2'd3; end
                3'd4: begin ok = (f7 == 7'h00); e.sl = 1'b1; e.op = 2'd2; end
                3'd5: begin ok = (f7 == 7'h00) || (f7 == 7'h20); e.ss = 1'b1; e.op = (f7 == 7'h20) ? 2'd2 : 2'd1; end
                3'd6: begin ok = (f7 == 7'h00); e.sl = 1'b1; e.op = 2'd1; end
                default: begin ok = (f7 == 7'h00); e.sl = 1'b1; e.op = 2'd0; end
            endcase
        end else if (insn[6:0] == 7'h13) begin
            e.ra = r1;
            e.rb = immi;
            case (f3)
                3'd0: begin ok = 1'b1; e.op = 2'd0; end
                3'd1: begin ok = (f7 == 7'h00); e.ss = 1'b1; e.op = 2'd0; e.rb = {27'b0, insn[24:20]}; end
                3'd2: begin ok = 1'b1; e.op = 2'd2; end
                3'd3: begin ok = 1'b1; e.op = 2'd3; end
                3'd4: begin ok = 1'b1; e.sl = 1'b1; e.op = 2'd2; end
                3'd5: begin
                    ok = (f7 == 7'h00) || (f7 == 7'h20); e.ss = 1'b1;
                    e.op = (f7 == 7'h20) ? 2'd2 : 2'd1; e.rb = {27'b0, insn[24:20]};
                end
                3'd6: begin ok = 1'b1; e.sl = 1'b1; e.op = 2'd1; end
                default: begin ok = 1'b1; e.sl = 1'b1; e.op = 2'd0; end
            endcase
        end else if (insn[6:0] == 7'h37) begin
            ok = 1'b1; e.sl = 1'b1; e.op = 2'd3; e.ra = 32'd0; e.rb = immu;
        end else if (insn[6:0] == 7'h17) begin
            ok = 1'b1; e.op = 2'd0; e.ra = pc; e.rb = immu;
        end
        if (!ok) begin
            e.ra = 32'd0; e.rb = 32'd0; e.sl = 1'b0; e.ss = 1'b0; e.op = 2'd0;
        end
        e.ill = !ok;
        e.we  = ok && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic check_outputs();
        check("in_ready", 32'(in_ready), 32'(m_ready));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("rs1_addr", 32'(rs1_addr), 32'(in_insn[19:15]));
        check("rs2_addr", 32'(rs2_addr), 32'(in_insn[24:20]));
        if (q.size() > 0) begin
            check("ra", out_ra, q[0].ra);
            check("rb", out_rb, q[0].rb);
            check("sel_logic", 32'(out_sel_logic), 32'(q[0].sl));
            check("sel_shift", 32'(out_sel_shift), 32'(q[0].ss));
            check("op", 32'(out_op), 32'(q[0].op));
            check("rd", 32'(out_rd), 32'(q[0].rd));
            check("we", 32'(out_we), 32'(q[0].we));
            check("illegal", 32'(out_illegal), 32'(q[0].ill));
        end
    endtask

    // One clock: drive at negedge, advance the queue model at posedge, check just after.
    task automatic step(input logic v, input logic [31:0] insn, input logic ordy,
                        input logic fl, input logic [31:0] r1, input logic [31:0] r2);
        exp_t d;
        logic acc;
        logic iss;
        @(negedge clk);
        in_valid  = v;
        in_insn   = insn;
        in_pc     = $urandom;
        rs1_data  = r1;
        rs2_data  = r2;
        out_ready = ordy;
        flush     = fl;
        d   = ref_decode(insn, in_pc, r1, r2);
        acc = v && m_ready;
        iss = (q.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (iss) void'(q.pop_front());
            if (acc) q.push_back(d);
        end
        m_ready = (q.size() < 2);
        check_outputs();
    endtask

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        logic [6:0]  f7;
        int          s;
        r = $urandom;
        s = $urandom_range(0, 9);
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        if (s <= 3)      r[6:0] = 7'h33;
        else if (s <= 6) r[6:0] = 7'h13;
        else if (s == 7) r[6:0] = 7'h37;
        else if (s == 8) r[6:0] = 7'h17;
        if (s <= 6) r[31:25] = f7;
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_insn   = 32'd0;
        in_pc     = 32'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;
        out_ready = 1'b0;
        m_ready   = 1'b1;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_ra", out_ra, 32'd0);
        check("rst_rd", 32'(out_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD x3,x1,x2
        step(1'b1, r_type(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 1'b1, 1'b0, 32'd5, 32'd7);
        check("add_ra", out_ra, 32'd5);
        check("add_rb", out_rb, 32'd7);
        check("add_op", 32'(out_op), 32'd0);
        check("add_rd", 32'(out_rd), 32'd3);
        check("add_we", 32'(out_we), 32'd1);

        // SUB x4,x1,x2 then SRAI x6,x1,3 back to back
        step(1'b1, r_type(7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33), 1'b1, 1'b0, 32'd9, 32'd4);
        check("sub_op", 32'(out_op), 32'd1);
        check("sub_rd", 32'(out_rd), 32'd4);
        step(1'b1, r_type(7'h20, 5'd3, 5'd1, 3'd5, 5'd6, 7'h13), 1'b1, 1'b0, 32'd9, 32'd4);
        check("srai_shift", 32'(out_sel_shift), 32'd1);
        check("srai_op", 32'(out_op), 32'd2);
        check("srai_rb", out_rb, 32'd3);

        // LUI x5,0x12345 ; ADDI x0,x0,-1
        step(1'b1, 32'h123452B7, 1'b1, 1'b0, 32'hDEAD, 32'hBEEF);
        check("lui_logic", 32'(out_sel_logic), 32'd1);
        check("lui_op", 32'(out_op), 32'd3);
        check("lui_ra", out_ra, 32'd0);
        check("lui_rb", out_rb, 32'h12345000);
        step(1'b1, 32'hFFF00013, 1'b1, 1'b0, 32'd0, 32'd0);
        check("addi_rb", out_rb, 32'hFFFFFFFF);
        check("addi_we", 32'(out_we), 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);

        // Backpressure: three offered, two held, then drained in order
        step(1'b1, {12'd1, 5'd0, 3'd0, 5'd7, 7'h13}, 1'b0, 1'b0, 32'd1, 32'd0);
        step(1'b1, {12'd2, 5'd0, 3'd0, 5'd8, 7'h13}, 1'b0, 1'b0, 32'd1, 32'd0);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        step(1'b1, {12'd3, 5'd0, 3'd0, 5'd9, 7'h13}, 1'b0, 1'b0, 32'd1, 32'd0);
        check("bp_hold_rd", 32'(out_rd), 32'd7);
        step(1'b1, {12'd3, 5'd0, 3'd0, 5'd9, 7'h13}, 1'b1, 1'b0, 32'd1, 32'd0);
        check("bp_second_rd", 32'(out_rd), 32'd8);
        step(1'b1, {12'd3, 5'd0, 3'd0, 5'd9, 7'h13}, 1'b1, 1'b0, 32'd1, 32'd0);
        check("bp_third_rd", 32'(out_rd), 32'd9);
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
        check("bp_drained", 32'(out_valid), 32'd0);

        // Illegal encodings
        step(1'b1, 32'h0000007F, 1'b1, 1'b0, 32'd1, 32'd2);
        check("ill_opc", 32'(out_illegal), 32'd1);
        check("ill_opc_we", 32'(out_we), 32'd0);
        step(1'b1, r_type(7'h01, 5'd2, 5'd1, 3'd0, 5'd10, 7'h33), 1'b1, 1'b0, 32'd1, 32'd2);
        check("ill_f7", 32'(out_illegal), 32'd1);
        check("ill_f7_ra", out_ra, 32'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);

        // Flush while FULL with an incoming instruction
        step(1'b1, rand_insn(), 1'b0, 1'b0, $urandom, $urandom);
        step(1'b1, rand_insn(), 1'b0, 1'b0, $urandom, $urandom);
        step(1'b1, rand_insn(), 1'b0, 1'b1, $urandom, $urandom);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), rand_insn(), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 24) == 0), $urandom, $urandom);
        end

        // Asynchronous reset in the middle of a stream
        step(1'b1, rand_insn(), 1'b0, 1'b0, $urandom, $urandom);
        step(1'b1, rand_insn(), 1'b0, 1'b0, $urandom, $urandom);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_ready = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_ra", out_ra, 32'd0);
        check("mid_rst_rb", out_rb, 32'd0);
        check("mid_rst_rd", 32'(out_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(($urandom_range(0, 3) != 0), rand_insn(), ($urandom_range(0, 1) != 0),
                 1'b0, $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
